// File: rtl/comporta_servo_pwm.sv
// Gate servo datapath: up/down position counter with end flags, and a servo PWM
// whose pulse width only changes on period boundaries.
module comporta_servo_pwm #(
    parameter int PERIODO     = 1_000_000,
    parameter int LARGURA_MIN = 50_000,
    parameter int PASSO       = 5_000,
    parameter int NUM_POS     = 11,
    parameter int W_CONT      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       zeraUpdown,
    input  logic       contaUpdown,
    output logic       pwm,
    output logic       inicioPosicao,
    output logic       fimPosicao,
    output logic       descendo,
    output logic [3:0] dbPosicao
);

    localparam logic [3:0]        POS_MAX    = 4'(NUM_POS - 1);
    localparam logic [W_CONT-1:0] CONT_MAX   = W_CONT'(PERIODO - 1);
    localparam logic [W_CONT-1:0] LARG_MIN_W = W_CONT'(LARGURA_MIN);
    localparam logic [W_CONT-1:0] PASSO_W    = W_CONT'(PASSO);

    logic [3:0]        posicao;
    logic [3:0]        pos_mais;
    logic [3:0]        pos_menos;
    logic [W_CONT-1:0] contador;
    logic [W_CONT-1:0] largura;
    logic [W_CONT-1:0] alvo;

    assign pos_mais  = posicao + 4'd1;
    assign pos_menos = posicao - 4'd1;

    // Direction flips on the same edge that reaches an end, so the next step
    // always moves back inward and the position can never wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            posicao  <= 4'd0;
            descendo <= 1'b0;
        end else if (zeraUpdown) begin
            posicao  <= 4'd0;
            descendo <= 1'b0;
        end else if (contaUpdown) begin
            if (!descendo) begin
                posicao <= pos_mais;
                if (pos_mais == POS_MAX) descendo <= 1'b1;
            end else begin
                posicao <= pos_menos;
                if (pos_menos == 4'd0) descendo <= 1'b0;
            end
        end
    end

    assign alvo = LARG_MIN_W + W_CONT'(posicao) * PASSO_W;

    // Width is latched only on the wrap edge so a pulse is never cut short
    // or stretched by a position change in mid-period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador <= '0;
            largura  <= LARG_MIN_W;
            pwm      <= 1'b0;
        end else begin
            pwm <= (contador < largura);
            if (contador == CONT_MAX) begin
                contador <= '0;
                largura  <= alvo;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

    assign inicioPosicao = (posicao == 4'd0);
    assign fimPosicao    = (posicao == POS_MAX);
    assign dbPosicao     = posicao;

endmodule
